mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates the single-port 16-bit data memory between two requesters: the processor datapath/control pair (CPU port) and a loader/DMA engine (DMA port).
- Sequences every access through a fixed issue/wait/acknowledge state machine.
- Drives a stall to the control unit while a CPU access is pending.
- Applies fixed CPU priority with an anti-starvation override for DMA.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory data width.
- MEM_LAT, 1, memory read latency in cycles after the issue cycle. Legal range is 1..4.
- STARVE_MAX, 4, consecutive CPU wins while DMA is waiting before DMA is forced. Legal range is 1..15.

Ports:
- CLK  input  1  clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cpu_req  input  1  CPU access request.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  ADDR_W  CPU address.
- cpu_wdata  input  DATA_W  CPU write data.
- cpu_rdata  output  DATA_W  CPU read data (registered).
- cpu_ack  output  1  one-cycle completion pulse to the CPU.
- cpu_stall  output  1  equals cpu_req & ~cpu_ack.
- dma_req  input  1  DMA access request.
- dma_we  input  1  1 = write, 0 = read.
- dma_addr  input  ADDR_W  DMA address.
- dma_wdata  input  DATA_W  DMA write data.
- dma_rdata  output  DATA_W  DMA read data (registered).
- dma_ack  output  1  one-cycle completion pulse to the DMA.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data.
- owner  output  2  current owner: 00 none, 01 CPU, 10 DMA.

Behaviour:
- Clock and reset: one clock CLK; reset is synchronous and active-high.
- Reset values: state IDLE; all outputs 0, including cpu_rdata, dma_rdata and owner; starve counter 0.
- Reset mid-access: the access is aborted. No ack is issued and mem_en is 0 from the next cycle.
- State machine: IDLE -> ISSUE -> (WAIT, reads only) -> DONE -> IDLE.
- IDLE:
  - If either req is high, the winner's we/addr/wdata are latched, owner is set, and the FSM moves to ISSUE.
  - Otherwise it stays in IDLE with owner = 00.
- Arbitration:
  - CPU wins ties.
  - Exception: DMA wins when dma_req = 1 and the starve counter equals STARVE_MAX.
- Starve counter:
  - Increments, saturating, on each CPU grant made while dma_req = 1.
  - Clears on any DMA grant.
  - Clears on a CPU grant made while dma_req = 0.
- ISSUE (one cycle, call it cycle T):
  - mem_en = 1; mem_we, mem_addr and mem_wdata come from the latched values.
  - Writes go to DONE. Reads go to WAIT.
  - mem_en and mem_we are 0 in every other state. mem_addr and mem_wdata hold their last values.
- WAIT:
  - Counts MEM_LAT cycles.
  - mem_rdata is sampled at the end of cycle T+MEM_LAT into the owner's rdata register.
  - The other requester's rdata is untouched.
- DONE:
  - The owner's ack = 1 for exactly one cycle.
  - Write ack appears at T+1. Read ack appears at T+MEM_LAT+1, with rdata already valid in that cycle.
  - The FSM then returns to IDLE and owner goes to 00.
- Requester rules:
  - req, we, addr and wdata must be held until ack; changes after the grant are ignored because the values are latched.
  - A req still high in the cycle after ack is a new request.
  - Minimum period is 3 cycles for a write and MEM_LAT+3 cycles for a read.
- Read data retention: rdata holds its value until that requester's next read completes.
- Deassertion: a req dropped before its grant is never served. A req dropped after its grant still completes and acks.
- Single owner: ack is never asserted to the non-owner, and both acks are never high together.

Test Plan:
- CPU write, no DMA:
  - Stimulus: cpu_req=1, we=1, addr=0x0010, wdata=0xBEEF presented in IDLE at cycle 0.
  - Response: cycle 1 has mem_en=1, mem_we=1, mem_addr=0x0010, mem_wdata=0xBEEF and owner=01. cycle 2 has cpu_ack=1. dma_ack stays 0.
- DMA read with MEM_LAT=2:
  - Stimulus: dma_req=1, addr=0x0200; memory returns 0x1234 at T+2.
  - Response: dma_ack and dma_rdata=0x1234 at T+3; cpu_rdata unchanged.
- Starvation with STARVE_MAX=4:
  - Stimulus: cpu_req and dma_req held high continuously, with CPU re-requesting back-to-back.
  - Response: grant order CPU, CPU, CPU, CPU, DMA, CPU; counter reads 0 after the DMA grant.
- Reset during WAIT:
  - Stimulus: CPU read with MEM_LAT=3; reset pulsed at T+1.
  - Response: no cpu_ack; mem_en=0 and owner=00 the next cycle. A subsequent write completes normally.
- Latching:
  - Stimulus: cpu_addr changed from 0x0040 to 0x0099 during WAIT.
  - Response: mem_addr stays 0x0040; the read returns data for 0x0040.
- Stall:
  - Stimulus: CPU read with MEM_LAT=1.
  - Response: cpu_stall=1 from the req cycle through T+1; cpu_stall=0 in the ack cycle T+2; a concurrent dma_req waits and is issued at T+4.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port data memory between the CPU and a
// DMA/loader port. Every access walks IDLE -> ISSUE -> (WAIT) -> DONE. The CPU
// has fixed priority, and a DMA requester is forced through after STARVE_MAX
// consecutive CPU wins.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
);

    localparam int unsigned CNT_W    = 3;
    localparam int unsigned STARVE_W = 4;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_DMA  = 2'b10;

    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(STARVE_MAX);
    localparam logic [STARVE_W-1:0] STARVE_SAT   = '1;
    localparam logic [CNT_W-1:0]    WAIT_LAST    = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                dma_ack_q, dma_ack_d;
    logic                dma_win;

    // State register
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: arbitration, request latching, latency count, read capture
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        dma_win     = dma_req & (~cpu_req | (starve_q == STARVE_LIMIT));

        case (state_q)
            S_IDLE: begin
                owner_d = OWN_NONE;
                if (dma_win) begin
                    owner_d  = OWN_DMA;
                    we_d     = dma_we;
                    addr_d   = dma_addr;
                    wdata_d  = dma_wdata;
                    starve_d = '0;
                    state_d  = S_ISSUE;
                end else if (cpu_req) begin
                    owner_d  = OWN_CPU;
                    we_d     = cpu_we;
                    addr_d   = cpu_addr;
                    wdata_d  = cpu_wdata;
                    state_d  = S_ISSUE;
                    if (!dma_req) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_SAT) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = we_q ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_DONE;
                    if (owner_q == OWN_CPU) begin
                        cpu_rdata_d = mem_rdata;
                    end else if (owner_q == OWN_DMA) begin
                        dma_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                owner_d = OWN_NONE;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the upcoming state so they can be registered
    always_comb begin
        mem_en_d  = 1'b0;
        mem_we_d  = 1'b0;
        cpu_ack_d = 1'b0;
        dma_ack_d = 1'b0;
        if (state_d == S_ISSUE) begin
            mem_en_d = 1'b1;
            mem_we_d = we_d;
        end
        if (state_d == S_DONE) begin
            cpu_ack_d = (owner_d == OWN_CPU);
            dma_ack_d = (owner_d == OWN_DMA);
        end
    end

    // Datapath and output registers
    always_ff @(posedge CLK) begin
        if (reset) begin
            owner_q     <= OWN_NONE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            starve_q    <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
        end
    end

    assign owner     = owner_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;
    // Stall is a direct function of the live request and the registered ack
    assign cpu_stall = cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter with MEM_LAT=2, STARVE_MAX=4: a per-cycle vector
// table followed by hand-written sequences for deassertion, reset, starvation.
module tb_mem_port_arbiter;

    localparam int unsigned LAT = 2;

    logic        CLK = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'hDEAD;
    logic        cpu_ack, cpu_stall, dma_ack, mem_en, mem_we;
    logic [1:0]  owner;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(
        .ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT), .STARVE_MAX(4)
    ) dut (
        .CLK(CLK), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
    );

    // Memory contents as a pure function of address
    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return (a == 16'h0200) ? 16'h1234 : (a ^ 16'hA5A5);
    endfunction

    // Memory model: read data valid only during cycle T+LAT, garbage otherwise
    logic [2:0]  rd_cnt  = '0;
    logic [15:0] rd_addr = '0;
    always @(posedge CLK) begin
        logic [2:0]  nxt;
        logic [15:0] a;
        if (mem_en === 1'b1 && mem_we === 1'b0) nxt = 3'd1;
        else if (rd_cnt != 3'd0 && rd_cnt < 3'(LAT)) nxt = rd_cnt + 3'd1;
        else nxt = 3'd0;
        a = (mem_en === 1'b1 && mem_we === 1'b0) ? mem_addr : rd_addr;
        rd_cnt    <= nxt;
        rd_addr   <= a;
        mem_rdata <= (nxt == 3'(LAT)) ? mem_val(a) : 16'hDEAD;
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_idle();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    endtask

    typedef struct {
        logic        rst;
        logic        creq;
        logic        cwe;
        logic [15:0] caddr;
        logic [15:0] cwd;
        logic        dreq;
        logic        dwe;
        logic [15:0] daddr;
        logic [15:0] dwd;
        logic        en;
        logic        we;
        logic [15:0] maddr;
        logic [15:0] mwd;
        logic [1:0]  own;
        logic        cack;
        logic        dack;
        logic        stall;
        logic [15:0] crd;
        logic [15:0] drd;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];
    logic [1:0] starve_exp [10];

    initial begin
        // rst creq cwe caddr cwd dreq dwe daddr dwd | en we maddr mwd own cack dack stall crd drd
        // reset held with a CPU write pending, then CPU write 0x0010 <- 0xBEEF
        vecs[0]  = '{1'b1,1'b1,1'b1,16'h0010,16'hBEEF,1'b0,1'b0,16'h0000,16'h0000,
                     1'b0,1'b0,16'h0000,16'h0000,2'b00,1'b0,1'b0,1'b1,16'h0000,16'h0000};
        vecs[1]  = '{1'b0,1'b1,1'b1,16'h0010,16'hBEEF,1'b0,1'b0,16'h0000,16'h0000,
                     1'b0,1'b0,16'h0000,16'h0000,2'b00,1'b0,1'b0,1'b1,16'h0000,16'h0000};
        vecs[2]  = '{1'b0,1'b1,1'b1,16'h0010,16'hBEEF,1'b0,1'b0,16'h0000,16'h0000,
                     1'b1,1'b1,16'h0010,16'hBEEF,2'b01,1'b0,1'b0,1'b1,16'h0000,16'h0000};
        vecs[3]  = '{1'b0,1'b1,1'b1,16'h0010,16'hBEEF,1'b0,1'b0,16'h0000,16'h0000,
                     1'b0,1'b0,16'h0010,16'hBEEF,2'b01,1'b1,1'b0,1'b0,16'h0000,16'h0000};
        vecs[4]  = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,16'h0000,16'h0000,
                     1'b0,1'b0,16'h0010,16'hBEEF,2'b00,1'b0,1'b0,1'b0,16'h0000,16'h0000};
        // DMA read of 0x0200, memory returns 0x1234 at T+2, ack at T+3
        vecs[5]  = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b0,16'h0200,16'h0000,
                     1'b0,1'b0,16'h0010,16'hBEEF,2'b00,1'b0,1'b0,1'b0,16'h0000,16'h0000};
        vecs[6]  = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b0,16'h0200,16'h0000,
                     1'b1,1'b0,16'h0200,16'h0000,2'b10,1'b0,1'b0,1'b0,16'h0000,16'h0000};
        vecs[7]  = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b0,16'h0200,16'h0000,
                     1'b0,1'b0,16'h0200,16'h0000,2'b10,1'b0,1'b0,1'b0,16'h0000,16'h0000};
        vecs[8]  = vecs[7];
        vecs[9]  = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b0,16'h0200,16'h0000,
                     1'b0,1'b0,16'h0200,16'h0000,2'b10,1'b0,1'b1,1'b0,16'h0000,16'h1234};
        vecs[10] = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,16'h0000,16'h0000,
                     1'b0,1'b0,16'h0200,16'h0000,2'b00,1'b0,1'b0,1'b0,16'h0000,16'h1234};
        // CPU read 0x0040, address changed to 0x0099 during WAIT
        vecs[11] = '{1'b0,1'b1,1'b0,16'h0040,16'h0000,1'b0,1'b0,16'h0000,16'h0000,
                     1'b0,1'b0,16'h0200,16'h0000,2'b00,1'b0,1'b0,1'b1,16'h0000,16'h1234};
        vecs[12] = '{1'b0,1'b1,1'b0,16'h0040,16'h0000,1'b0,1'b0,16'h0000,16'h0000,
                     1'b1,1'b0,16'h0040,16'h0000,2'b01,1'b0,1'b0,1'b1,16'h0000,16'h1234};
        vecs[13] = '{1'b0,1'b1,1'b0,16'h0099,16'h0000,1'b0,1'b0,16'h0000,16'h0000,
                     1'b0,1'b0,16'h0040,16'h0000,2'b01,1'b0,1'b0,1'b1,16'h0000,16'h1234};
        vecs[14] = vecs[13];
        vecs[15] = '{1'b0,1'b1,1'b0,16'h0099,16'h0000,1'b0,1'b0,16'h0000,16'h0000,
                     1'b0,1'b0,16'h0040,16'h0000,2'b01,1'b1,1'b0,1'b0,16'hA5E5,16'h1234};
        vecs[16] = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,16'h0000,16'h0000,
                     1'b0,1'b0,16'h0040,16'h0000,2'b00,1'b0,1'b0,1'b0,16'hA5E5,16'h1234};
        // CPU read 0x0300 wins tie over DMA write; stall drops in ack cycle; DMA follows
        vecs[17] = '{1'b0,1'b1,1'b0,16'h0300,16'h0000,1'b1,1'b1,16'h0400,16'h5555,
                     1'b0,1'b0,16'h0040,16'h0000,2'b00,1'b0,1'b0,1'b1,16'hA5E5,16'h1234};
        vecs[18] = '{1'b0,1'b1,1'b0,16'h0300,16'h0000,1'b1,1'b1,16'h0400,16'h5555,
                     1'b1,1'b0,16'h0300,16'h0000,2'b01,1'b0,1'b0,1'b1,16'hA5E5,16'h1234};
        vecs[19] = '{1'b0,1'b1,1'b0,16'h0300,16'h0000,1'b1,1'b1,16'h0400,16'h5555,
                     1'b0,1'b0,16'h0300,16'h0000,2'b01,1'b0,1'b0,1'b1,16'hA5E5,16'h1234};
        vecs[20] = vecs[19];
        vecs[21] = '{1'b0,1'b1,1'b0,16'h0300,16'h0000,1'b1,1'b1,16'h0400,16'h5555,
                     1'b0,1'b0,16'h0300,16'h0000,2'b01,1'b1,1'b0,1'b0,16'hA6A5,16'h1234};
        vecs[22] = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b1,16'h0400,16'h5555,
                     1'b0,1'b0,16'h0300,16'h0000,2'b00,1'b0,1'b0,1'b0,16'hA6A5,16'h1234};
        vecs[23] = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b1,16'h0400,16'h5555,
                     1'b1,1'b1,16'h0400,16'h5555,2'b10,1'b0,1'b0,1'b0,16'hA6A5,16'h1234};
        vecs[24] = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b1,16'h0400,16'h5555,
                     1'b0,1'b0,16'h0400,16'h5555,2'b10,1'b0,1'b1,1'b0,16'hA6A5,16'h1234};
        vecs[25] = '{1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0,16'h0000,16'h0000,
                     1'b0,1'b0,16'h0400,16'h5555,2'b00,1'b0,1'b0,1'b0,16'hA6A5,16'h1234};

        starve_exp = '{2'b01,2'b01,2'b01,2'b01,2'b10,2'b01,2'b01,2'b01,2'b01,2'b10};

        drive_idle();
        reset = 1'b1;
        tick();
        tick();

        // Table: drive each cycle's inputs, compare mid-cycle on the falling edge
        for (int i = 0; i < NV; i++) begin
            reset     = vecs[i].rst;
            cpu_req   = vecs[i].creq;  cpu_we  = vecs[i].cwe;
            cpu_addr  = vecs[i].caddr; cpu_wdata = vecs[i].cwd;
            dma_req   = vecs[i].dreq;  dma_we  = vecs[i].dwe;
            dma_addr  = vecs[i].daddr; dma_wdata = vecs[i].dwd;
            @(negedge CLK);
            chk($sformatf("v%0d.mem_en", i),    16'(mem_en),    16'(vecs[i].en));
            chk($sformatf("v%0d.mem_we", i),    16'(mem_we),    16'(vecs[i].we));
            chk($sformatf("v%0d.mem_addr", i),  mem_addr,       vecs[i].maddr);
            chk($sformatf("v%0d.mem_wdata", i), mem_wdata,      vecs[i].mwd);
            chk($sformatf("v%0d.owner", i),     16'(owner),     16'(vecs[i].own));
            chk($sformatf("v%0d.cpu_ack", i),   16'(cpu_ack),   16'(vecs[i].cack));
            chk($sformatf("v%0d.dma_ack", i),   16'(dma_ack),   16'(vecs[i].dack));
            chk($sformatf("v%0d.cpu_stall", i), 16'(cpu_stall), 16'(vecs[i].stall));
            chk($sformatf("v%0d.cpu_rdata", i), cpu_rdata,      vecs[i].crd);
            chk($sformatf("v%0d.dma_rdata", i), dma_rdata,      vecs[i].drd);
            @(posedge CLK);
            #1;
        end

        // CPU drops req after grant (still served); DMA pulse before grant (never served)
        begin
            int ack_cyc = -1;
            int acks    = 0;
            int dma_seen = 0;
            drive_idle();
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0070;
            tick();
            chk("drop.issue_en", 16'(mem_en), 16'd1);
            chk("drop.issue_addr", mem_addr, 16'h0070);
            cpu_req = 1'b0;
            dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0800; dma_wdata = 16'h0808;
            for (int k = 1; k <= 10; k++) begin
                tick();
                if (k == 1) dma_req = 1'b0;
                if (cpu_ack) begin acks++; ack_cyc = k; end
                if (dma_ack || owner == 2'b10 || (mem_en && mem_addr == 16'h0800)) dma_seen++;
            end
            chk("drop.cpu_ack_count", 16'(acks), 16'd1);
            chk("drop.cpu_ack_cycle", 16'(ack_cyc), 16'd3);
            chk("drop.cpu_rdata", cpu_rdata, 16'hA5D5);
            chk("drop.dma_never_served", 16'(dma_seen), 16'd0);
        end

        // Reset during WAIT aborts the read; next write completes normally
        begin
            int acks = 0;
            drive_idle();
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0050;
            tick();
            chk("rst.issue_owner", 16'(owner), 16'(2'b01));
            tick();
            reset = 1'b1; cpu_req = 1'b0;
            tick();
            reset = 1'b0;
            chk("rst.mem_en", 16'(mem_en), 16'd0);
            chk("rst.owner", 16'(owner), 16'd0);
            chk("rst.cpu_ack", 16'(cpu_ack), 16'd0);
            chk("rst.cpu_rdata", cpu_rdata, 16'h0000);
            chk("rst.dma_rdata", dma_rdata, 16'h0000);
            for (int k = 0; k < 4; k++) begin
                tick();
                if (cpu_ack || mem_en) acks++;
            end
            chk("rst.no_late_activity", 16'(acks), 16'd0);
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0060; cpu_wdata = 16'h7777;
            tick();
            chk("rst.wr_en", 16'(mem_en), 16'd1);
            chk("rst.wr_we", 16'(mem_we), 16'd1);
            chk("rst.wr_addr", mem_addr, 16'h0060);
            chk("rst.wr_wdata", mem_wdata, 16'h7777);
            tick();
            chk("rst.wr_ack", 16'(cpu_ack), 16'd1);
            cpu_req = 1'b0;
            tick();
            chk("rst.wr_idle_owner", 16'(owner), 16'd0);
        end

        // Starvation: both ports hold requests; grant order C C C C D repeated
        begin
            logic [1:0] grants [10];
            int n    = 0;
            int both = 0;
            reset = 1'b1;
            tick();
            reset = 1'b0;
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 16'h1111;
            dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0200; dma_wdata = 16'h2222;
            for (int c = 0; c < 80 && n < 10; c++) begin
                tick();
                if (cpu_ack && dma_ack) both++;
                if (mem_en) begin
                    grants[n] = owner;
                    n++;
                end
            end
            chk("starve.grant_count", 16'(n), 16'd10);
            for (int k = 0; k < 10; k++) begin
                if (k < n) chk($sformatf("starve.grant%0d", k), 16'(grants[k]), 16'(starve_exp[k]));
            end
            chk("starve.no_double_ack", 16'(both), 16'd0);
            drive_idle();
            tick();
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
